uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning width of a received data word.
REQ-002 SHALL have parameter DEPTH, default 4, meaning log2 of the entry count (16 entries).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port re, input, 1, single-cycle receive strobe from the uart receiver.
REQ-006 SHALL have port data_rx, input, WIDTH, received word, valid when re=1.
REQ-007 SHALL have port rd_en, input, 1, pop request from the consumer.
REQ-008 SHALL have port rd_data, output, WIDTH, popped word, registered.
REQ-009 SHALL have port rd_valid, output, 1, one-cycle pulse: rd_data holds a newly popped word.
REQ-010 SHALL have port empty, output, 1, high when count=0.
REQ-011 SHALL have port full, output, 1, high when count=2^DEPTH.
REQ-012 SHALL have port count, output, DEPTH+1, current number of stored words.
REQ-013 SHALL have port overflow, output, 1, sticky flag: a word was dropped.
REQ-014 SHALL have port clear_overflow, input, 1, clears overflow.
REQ-015 SHALL have port lines, output, DEPTH+1, number of LF (0x0A) words stored (see Configuration).

Function
REQ-016 SHALL store words in a circular buffer with DEPTH-bit write and read pointers wrapping 2^DEPTH-1 -> 0.
REQ-017 SHALL accept a write when re=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-018 SHALL accept a pop when rd_en=1 and empty=0; rd_en with empty=1 is ignored, no rd_valid.
REQ-019 SHALL present the popped word on rd_data with rd_valid=1 exactly one cycle after the accepted pop; rd_data holds its value until the next accepted pop.
REQ-020 SHALL, on simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL, on re=1 while full=1 with no pop, drop the word, leave the buffer unchanged and set overflow the next cycle.
REQ-022 SHALL give clear_overflow priority below a same-cycle drop: overflow stays 1.
REQ-023 SHALL update count, empty and full registered, one cycle after the causing edge.
REQ-024 SHALL never write to the entry being popped unless count=2^DEPTH with simultaneous pop (slot reuse is then permitted: the read captures the old word).

Reset
REQ-025 SHALL, on reset=1 at a clock edge, set pointers=0, count=0, empty=1, full=0, overflow=0, rd_valid=0, rd_data=0, lines=0.
REQ-026 SHALL let reset override re, rd_en and clear_overflow in the same cycle; buffer contents need not be cleared.
REQ-027 SHALL discard all stored words and any in-flight pop when reset is asserted mid-operation; rd_valid=0 the following cycle.

Configuration
REQ-028 SHALL implement line counting only when macro UART_RX_FIFO_LINE_COUNT_EN is defined.
REQ-029 SHALL, with the macro, increment lines on an accepted write of 0x0A, decrement it on an accepted pop of 0x0A, and leave it unchanged when both occur together.
REQ-030 SHALL, with the macro, never increment lines for a dropped word.
REQ-031 SHALL, without the macro, drive lines constantly 0 and contain no line-count logic.

Verification
REQ-032 SHALL cover: reset, write 0x41,0x42,0x43 -> count=3; three pops -> rd_data 0x41,0x42,0x43 each with rd_valid, then empty=1.
REQ-033 SHALL cover: write 17 words 0x00..0x10 with no pops -> full=1, count=16, overflow=1; pops return 0x00..0x0F, 0x10 lost.
REQ-034 SHALL cover: full buffer, re=1 with rd_en=1 same cycle -> no overflow, count stays 16, new word returned after 15 further pops.
REQ-035 SHALL cover: rd_en=1 while empty -> rd_valid stays 0, count stays 0; wrap test of 40 write/pop pairs returns data in order.
REQ-036 SHALL cover: overflow=1, clear_overflow=1 -> overflow=0 next cycle; clear coinciding with a drop -> overflow stays 1.
REQ-037 SHALL cover (macro defined): write "A",0x0A,"B",0x0A -> lines=2; pop two words -> lines=1; reset -> lines=0; without macro lines=0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side FIFO sitting between a UART receiver and its consumer.
//
// Words arrive on single-cycle re strobes and are stored in a circular buffer
// of 2^DEPTH entries. The consumer pops with rd_en; the popped word appears on
// rd_data with a one-cycle rd_valid pulse on the following cycle. A word that
// arrives while the buffer is full, with no pop in the same cycle, is dropped
// and sets the sticky overflow flag.
//
// Optional feature: define UART_RX_FIFO_LINE_COUNT_EN to track the number of
// stored LF (0x0A) words on lines. Without the macro, lines is tied to 0.
//
// Ports:
//   clk            in   single clock, rising edge
//   reset          in   synchronous active-high reset
//   re             in   receive strobe, data_rx valid when high
//   data_rx        in   [WIDTH-1:0] received word
//   rd_en          in   pop request
//   clear_overflow in   clears the overflow flag (a same-cycle drop wins)
//   rd_data        out  [WIDTH-1:0] last popped word, held between pops
//   rd_valid       out  one-cycle pulse when rd_data is newly popped
//   empty          out  count == 0 (registered)
//   full           out  count == 2^DEPTH (registered)
//   count          out  [DEPTH:0] number of stored words
//   overflow       out  sticky: a word was dropped
//   lines          out  [DEPTH:0] number of stored LF words
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             re,
    input  logic [WIDTH-1:0] data_rx,
    input  logic             rd_en,
    input  logic             clear_overflow,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   count,
    output logic             overflow,
    output logic [DEPTH:0]   lines
);

    localparam int             ENTRIES  = 1 << DEPTH;
    localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(ENTRIES);
    localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
    localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);

    logic [WIDTH-1:0] mem [ENTRIES];
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic             pop_acc;
    logic             wr_acc;
    logic             drop;
    logic [DEPTH:0]   count_nxt;

    // A write into a full buffer is still accepted when a pop frees a slot in
    // the same cycle; the write then lands on the slot being read, and the
    // read captures the old word because the memory read sees pre-edge contents.
    always_comb begin
        pop_acc   = rd_en && !empty;
        wr_acc    = re && (!full || pop_acc);
        drop      = re && full && !pop_acc;
        count_nxt = count;
        if (wr_acc && !pop_acc) begin
            count_nxt = count + CNT_ONE;
        end else if (pop_acc && !wr_acc) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= pop_acc;
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == FULL_CNT);
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage has no reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem[wr_ptr] <= data_rx;
        end
    end

`ifdef UART_RX_FIFO_LINE_COUNT_EN
    localparam logic [WIDTH-1:0] LF = WIDTH'(8'h0A);

    logic           wr_lf;
    logic           pop_lf;
    logic [DEPTH:0] lines_q;

    assign wr_lf  = wr_acc && (data_rx == LF);
    assign pop_lf = pop_acc && (mem[rd_ptr] == LF);

    always_ff @(posedge clk) begin
        if (reset) begin
            lines_q <= '0;
        end else if (wr_lf && !pop_lf) begin
            lines_q <= lines_q + CNT_ONE;
        end else if (pop_lf && !wr_lf) begin
            lines_q <= lines_q - CNT_ONE;
        end
    end

    assign lines = lines_q;
`else
    assign lines = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       re = 1'b0;
    logic [7:0] data_rx = 8'h00;
    logic       rd_en = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [4:0] lines;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q [$];   // expected popped words, consumed by the monitor
    logic [7:0] m_q   [$];   // reference contents of the buffer
    logic       m_ovf = 1'b0;
    int         m_lines = 0;

    uart_rx_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .re             (re),
        .data_rx        (data_rx),
        .rd_en          (rd_en),
        .clear_overflow (clear_overflow),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .empty          (empty),
        .full           (full),
        .count          (count),
        .overflow       (overflow),
        .lines          (lines)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented word against the scoreboard queue.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_data_unexpected: got %0h expected no pop at %0t", rd_data, $time);
            end else begin
                chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus with the reference model updated alongside.
    task automatic cyc(input logic re_v, input logic [7:0] d, input logic rd_v, input logic clr);
        logic       pop;
        logic       wr;
        logic       full_m;
        logic [7:0] popped;
        full_m = (m_q.size() == 16);
        pop    = rd_v && (m_q.size() != 0);
        wr     = re_v && (!full_m || pop);
        popped = 8'h00;
        if (pop) begin
            popped = m_q.pop_front();
            exp_q.push_back(popped);
        end
        if (wr) m_q.push_back(d);
        if (re_v && full_m && !pop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
`ifdef UART_RX_FIFO_LINE_COUNT_EN
        if (wr && d == 8'h0A) m_lines++;
        if (pop && popped == 8'h0A) m_lines--;
`endif
        re = re_v; data_rx = d; rd_en = rd_v; clear_overflow = clr;
        @(posedge clk);
        #1;
        re = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
        chk("rd_valid", {31'h0, rd_valid}, {31'h0, pop});
        chk("count", {27'h0, count}, m_q.size());
        chk("empty", {31'h0, empty}, {31'h0, m_q.size() == 0});
        chk("full", {31'h0, full}, {31'h0, m_q.size() == 16});
        chk("overflow", {31'h0, overflow}, {31'h0, m_ovf});
        chk("lines", {27'h0, lines}, m_lines);
    endtask

    // Reset with all other inputs active to show reset overrides them.
    task automatic do_reset();
        reset = 1'b1; re = 1'b1; data_rx = 8'h0A; rd_en = 1'b1; clear_overflow = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; re = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_lines = 0;
        chk("rst_rd_valid", {31'h0, rd_valid}, 0);
        chk("rst_rd_data", {24'h0, rd_data}, 0);
        chk("rst_count", {27'h0, count}, 0);
        chk("rst_empty", {31'h0, empty}, 1);
        chk("rst_full", {31'h0, full}, 0);
        chk("rst_overflow", {31'h0, overflow}, 0);
        chk("rst_lines", {27'h0, lines}, 0);
    endtask

    initial begin
        do_reset();

        // Three writes then three pops.
        cyc(1, 8'h41, 0, 0);
        cyc(1, 8'h42, 0, 0);
        cyc(1, 8'h43, 0, 0);
        chk("count_after_3", {27'h0, count}, 3);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0);
        chk("empty_after_3_pops", {31'h0, empty}, 1);
        chk("rd_data_hold", {24'h0, rd_data}, 8'h43);

        // Seventeen writes: last one dropped.
        for (int i = 0; i < 17; i++) cyc(1, 8'(i), 0, 0);
        chk("full_17", {31'h0, full}, 1);
        chk("count_17", {27'h0, count}, 16);
        chk("overflow_17", {31'h0, overflow}, 1);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
        chk("empty_drained", {31'h0, empty}, 1);

        // Clear overflow, then simultaneous write and pop on a full buffer.
        cyc(0, 8'h00, 0, 1);
        chk("overflow_cleared", {31'h0, overflow}, 0);
        for (int i = 0; i < 16; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
        cyc(1, 8'h99, 1, 0);
        chk("full_pop_no_ovf", {31'h0, overflow}, 0);
        chk("full_pop_count", {27'h0, count}, 16);
        for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
        chk("new_word_last", {27'h0, count}, 1);
        cyc(0, 8'h00, 1, 0);
        chk("rd_data_99", {24'h0, rd_data}, 8'h99);

        // Pop while empty is ignored.
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("empty_pop_count", {27'h0, count}, 0);

        // 40 write/pop pairs wrap both pointers.
        for (int i = 0; i < 40; i++) begin
            cyc(1, 8'h80 + 8'(i), 0, 0);
            cyc(0, 8'h00, 1, 0);
        end
        chk("rd_data_wrap", {24'h0, rd_data}, 8'hA7);

        // Clear coinciding with a drop keeps overflow set.
        for (int i = 0; i < 16; i++) cyc(1, 8'h60 + 8'(i), 0, 0);
        cyc(1, 8'hEE, 0, 1);
        chk("clear_vs_drop", {31'h0, overflow}, 1);
        cyc(0, 8'h00, 0, 1);
        chk("clear_after_drop", {31'h0, overflow}, 0);
        for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);

        // Line counting.
        do_reset();
        cyc(1, 8'h41, 0, 0);
        cyc(1, 8'h0A, 0, 0);
        cyc(1, 8'h42, 0, 0);
        cyc(1, 8'h0A, 0, 0);
`ifdef UART_RX_FIFO_LINE_COUNT_EN
        chk("lines_2", {27'h0, lines}, 2);
`else
        chk("lines_off_a", {27'h0, lines}, 0);
`endif
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
`ifdef UART_RX_FIFO_LINE_COUNT_EN
        chk("lines_1", {27'h0, lines}, 1);
`else
        chk("lines_off_b", {27'h0, lines}, 0);
`endif
        // Reset mid-operation discards stored words and the line count.
        do_reset();
        cyc(0, 8'h00, 1, 0);
        chk("post_reset_empty", {31'h0, empty}, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
